// File: rtl/ifu_prefetch.sv
// Instruction prefetch: owns the PC, issues word fetches and queues in-order responses for decode.
// Optional IFU_MISALIGN_CHK_EN: misaligned redirect targets raise fetch_misalign_o and halt fetch.
module ifu_prefetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_i,
  input  logic [63:0] redirect_target_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] pc_o,
  output logic        fetch_misalign_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   fetch_pc, rsp_pc, target;
  logic [CW-1:0] count, outstanding, drop_cnt, inflight_nxt;
  logic [AW-1:0] head, tail;
  logic [31:0]   inst_q [DEPTH];
  logic [63:0]   pc_q   [DEPTH];
  logic          halted, credit, req_fire, deq, enq;

`ifdef IFU_MISALIGN_CHK_EN
  assign target = redirect_target_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_misalign_o <= 1'b0;
      halted           <= 1'b0;
    end else if (redirect_i) begin
      fetch_misalign_o <= |redirect_target_i[1:0];
      halted           <= |redirect_target_i[1:0];
    end
  end
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb   = ^redirect_target_i[1:0];
  assign target           = {redirect_target_i[63:2], 2'b00};
  assign fetch_misalign_o = 1'b0;
  assign halted           = 1'b0;
`endif

  // Credits cover queued entries plus every in-flight request, stale ones included.
  assign credit         = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
  assign imem_req_valid = rst_n & ~redirect_i & credit & ~halted;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign inst_valid_o   = (count != '0);
  assign deq            = inst_valid_o & inst_ready_i;
  assign enq            = imem_rsp_valid & (drop_cnt == '0);
  assign inst_o         = inst_q[head];
  assign pc_o           = pc_q[head];
  assign inflight_nxt   = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      outstanding <= inflight_nxt;
      if (redirect_i) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        // Everything still in flight is stale; outstanding already counts earlier stale requests.
        drop_cnt <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (enq) begin
          inst_q[tail] <= imem_rsp_data;
          pc_q[tail]   <= rsp_pc;
          tail         <= tail + 1'b1;
          rsp_pc       <= rsp_pc + 64'd4;
        end
        if (deq) head <= head + 1'b1;
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: memory and decode models, a queue-based reference, directed and random phases.
module tb_ifu_prefetch;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [63:0] imem_req_addr, redirect_target_i, pc_o;
  logic [31:0] imem_rsp_data, inst_o;
  logic        redirect_i, inst_valid_o, inst_ready_i, fetch_misalign_o;

  ifu_prefetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o), .pc_o(pc_o),
    .fetch_misalign_o(fetch_misalign_o));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  typedef struct { logic [63:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] inst; logic [63:0] pc; } ent_t;
  typedef struct { logic [63:0] target; logic exp_valid; logic [63:0] exp_addr; logic exp_mis; } vec_t;

  mreq_t mem_q[$];
  ent_t  ref_q[$];
  vec_t  vt[6];

  int n_cmp = 0, n_err = 0, cyc = 0, dut_fires = 0;
  logic [63:0] exp_fetch, last_fire_addr, hold_addr, d_target;
  logic exp_mis, exp_halt, hold_pending;
  logic d_req_ready, d_inst_ready, d_redir;
  int lat_lo, lat_hi;

  function automatic logic [31:0] mem_word(logic [63:0] a);
    return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check #1 later, advance the reference after the posedge.
  task automatic step();
    logic rv, ev, fire, deq;
    logic [31:0] rd;
    ent_t e;
    mreq_t m;
    rv = 1'b0; rd = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin rv = 1'b1; rd = mem_word(mem_q[0].addr); end
    imem_rsp_valid = rv; imem_rsp_data = rd;
    imem_req_ready = d_req_ready; inst_ready_i = d_inst_ready;
    redirect_i = d_redir; redirect_target_i = d_target;
    #1;
    ev = !d_redir && (ref_q.size() + mem_q.size() < DEPTH) && !exp_halt;
    chk("req_valid", imem_req_valid, ev);
    if (ev) chk("req_addr", imem_req_addr, exp_fetch);
    if (hold_pending && !d_redir) chk("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, hold_addr});
    chk("inst_valid", inst_valid_o, ref_q.size() > 0);
    if (ref_q.size() > 0) begin
      chk("inst", inst_o, ref_q[0].inst);
      chk("pc", pc_o, ref_q[0].pc);
    end
    chk("misalign", fetch_misalign_o, exp_mis);
    if (imem_req_valid && imem_req_ready) begin dut_fires++; last_fire_addr = imem_req_addr; end
    fire = ev && d_req_ready;
    deq = (ref_q.size() > 0) && d_inst_ready;
    hold_pending = ev && !d_req_ready;
    hold_addr = exp_fetch;
    @(posedge clk);
    if (deq) void'(ref_q.pop_front());
    if (rv) begin
      m = mem_q.pop_front();
      if (!m.stale && !d_redir) begin e.inst = mem_word(m.addr); e.pc = m.addr; ref_q.push_back(e); end
    end
    if (fire) begin
      m.addr = exp_fetch; m.due = cyc + $urandom_range(lat_hi, lat_lo); m.stale = 1'b0;
      mem_q.push_back(m);
      exp_fetch = exp_fetch + 64'd4;
    end
    if (d_redir) begin
      ref_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
`ifdef IFU_MISALIGN_CHK_EN
      exp_fetch = d_target; exp_mis = |d_target[1:0]; exp_halt = exp_mis;
`else
      exp_fetch = {d_target[63:2], 2'b00};
`endif
    end
    @(negedge clk);
    cyc++;
  endtask

  // Entered and left at a negedge; reset is held for one full clock.
  task automatic do_reset();
    rst_n = 1'b0; imem_rsp_valid = 1'b0; redirect_i = 1'b0; d_redir = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid_o, 1'b0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", pc_o, 64'h0);
    chk("rst_misalign", fetch_misalign_o, 1'b0);
    mem_q.delete(); ref_q.delete();
    exp_fetch = RPC; exp_mis = 1'b0; exp_halt = 1'b0; hold_pending = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, f0;
    vt[0] = '{64'h8000_1000, 1'b1, 64'h8000_1000, 1'b0};
`ifdef IFU_MISALIGN_CHK_EN
    vt[1] = '{64'h8000_0002, 1'b0, 64'h0, 1'b1};
    vt[3] = '{64'h8000_0003, 1'b0, 64'h0, 1'b1};
`else
    vt[1] = '{64'h8000_0002, 1'b1, 64'h8000_0000, 1'b0};
    vt[3] = '{64'h8000_0003, 1'b1, 64'h8000_0000, 1'b0};
`endif
    vt[2] = '{64'h8000_0100, 1'b1, 64'h8000_0100, 1'b0};
    vt[4] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vt[5] = '{64'h8000_0000, 1'b1, 64'h8000_0000, 1'b0};

    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_i = 1'b0; redirect_target_i = '0; inst_ready_i = 1'b0;
    d_req_ready = 1'b1; d_inst_ready = 1'b1; d_redir = 1'b0; d_target = '0;
    lat_lo = 1; lat_hi = 1;
    @(negedge clk);

    // Streaming from reset with single-cycle memory.
    do_reset();
    run(12);

    // Decode stalled: exactly DEPTH requests, then resume at RESET_PC+16.
    do_reset();
    d_inst_ready = 1'b0; f0 = dut_fires;
    run(8);
    chk("stall_fires", dut_fires - f0, 4);
    d_inst_ready = 1'b1; f0 = dut_fires;
    k = 0;
    while (dut_fires == f0 && k < 6) begin step(); k++; end
    chk("resume_addr", last_fire_addr, 64'h8000_0010);
    run(6);

    // Redirect with two requests in flight.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    k = 0;
    while (mem_q.size() != 2 && k < 10) begin step(); k++; end
    chk("two_inflight", mem_q.size(), 2);
    d_redir = 1'b1; d_target = 64'h8000_1000; step(); d_redir = 1'b0;
    k = 0;
    while (!inst_valid_o && k < 12) begin step(); k++; end
    chk("redir_first_pc", pc_o, 64'h8000_1000);
    lat_lo = 1; lat_hi = 1;
    run(6);

    // Memory not ready: request held stable, one fetch on acceptance.
    do_reset();
    d_req_ready = 1'b0; f0 = dut_fires;
    run(5);
    d_req_ready = 1'b1;
    step();
    chk("held_fires", dut_fires - f0, 1);
    chk("held_addr", last_fire_addr, RPC);
    run(4);

    // Redirect target table, including misaligned targets and 64-bit wrap.
    for (int i = 0; i < 6; i++) begin
      run(3);
      d_redir = 1'b1; d_target = vt[i].target; step(); d_redir = 1'b0;
      redirect_i = 1'b0; imem_req_ready = 1'b1;
      #1;
      chk("tbl_misalign", fetch_misalign_o, vt[i].exp_mis);
      chk("tbl_valid", imem_req_valid, vt[i].exp_valid);
      if (vt[i].exp_valid) chk("tbl_addr", imem_req_addr, vt[i].exp_addr);
      run(3);
    end

    // Reset mid-stream with three queued entries.
    do_reset();
    d_inst_ready = 1'b0;
    k = 0;
    while (ref_q.size() != 3 && k < 10) begin step(); k++; end
    chk("three_queued", ref_q.size(), 3);
    do_reset();
    d_inst_ready = 1'b1; f0 = dut_fires;
    step();
    chk("restart_fires", dut_fires - f0, 1);
    chk("restart_addr", last_fire_addr, RPC);

    // Randomized traffic.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(499, 0) == 0) do_reset();
      d_req_ready  = ($urandom_range(3, 0) != 0);
      d_inst_ready = ($urandom_range(2, 0) != 0);
      d_redir      = ($urandom_range(19, 0) == 0);
      d_target     = RPC + {52'h0, 10'($urandom_range(1023, 0)), 2'b00};
      if ($urandom_range(3, 0) == 0) d_target[1:0] = 2'($urandom_range(3, 1));
      step();
    end
    d_redir = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
